// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush and EX operand forwarding,
// with saturating stall/flush event counters and a one-cycle INIT bubble after reset.
//
// state | meaning
// INIT  | held in reset or first cycle after release; pipeline frozen and flushed
// RUN   | normal hazard detection and forwarding
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        cnt_clr,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic INIT = 1'b0;
    localparam logic RUN  = 1'b1;

    logic state;
    logic lw_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= RUN;
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // MEM result is newer than WB, so it wins when both target the same source
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWriteM && (RdM != 5'd0) && (RdM == src))      return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == src)) return 2'b01;
        else                                                 return 2'b00;
    endfunction

    always_comb begin
        StallF    = 1'b1;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (state == RUN) begin
            StallF    = lw_stall && !PCSrcE;
            StallD    = lw_stall && !PCSrcE;
            FlushD    = PCSrcE;
            FlushE    = lw_stall || PCSrcE;
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (cnt_clr) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (state == RUN) begin
            if (StallD && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (PCSrcE && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, randomized run
// against a reference model, counter saturation and mid-stream reset.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, cnt_clr;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int fails  = 0;

    // reference model state
    bit m_run   = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
        logic       pcsrc;
        logic [7:0] exp;   // {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE}
    } vec_t;

    vec_t vecs[11];

    function automatic logic [7:0] actual_outs();
        return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    endfunction

    // Reference: which stage (if any) holds a newer value of register src
    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        int stage_rd[2];
        bit stage_wr[2];
        logic [1:0] code[2];
        stage_rd = '{int'(RdM), int'(RdW)};
        stage_wr = '{RegWriteM, RegWriteW};
        code     = '{2'b10, 2'b01};
        for (int s = 0; s < 2; s++)
            if (stage_wr[s] && stage_rd[s] != 0 && stage_rd[s] == int'(src)) return code[s];
        return 2'b00;
    endfunction

    function automatic logic [7:0] ref_outs();
        bit load_use, stall;
        if (!m_run) return 8'b1011_0000;
        load_use = (ResultSrcE == 2'd1) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        stall    = load_use && !PCSrcE;
        return {stall, stall, PCSrcE, load_use || PCSrcE, ref_fwd(Rs1E), ref_fwd(Rs2E)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cnts(input string name);
        check({name, " stall_cnt"}, int'(stall_cnt), m_stall);
        check({name, " flush_cnt"}, int'(flush_cnt), m_flush);
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0;
        RdM = 0; RegWriteM = 0; RdW = 0; RegWriteW = 0; PCSrcE = 0; cnt_clr = 0;
    endtask

    // advance one clock, updating the model from the inputs held this cycle
    task automatic tick();
        logic [7:0] o;
        o = ref_outs();
        if (cnt_clr) begin
            m_stall = 0; m_flush = 0;
        end else if (m_run) begin
            if (o[6] && m_stall < 65535) m_stall++;
            if (PCSrcE && m_flush < 65535) m_flush++;
        end
        if (!reset) m_run = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_vec(input vec_t v);
        set_idle();
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
        ResultSrcE = v.rsrc; RdM = v.rdm; RegWriteM = v.wm; RdW = v.rdw;
        RegWriteW = v.ww; PCSrcE = v.pcsrc;
    endtask

    initial begin
        vecs[0]  = '{"load rs1",      5, 0, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 8'b1101_0000};
        vecs[1]  = '{"load rd x0",    0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 8'b0000_0000};
        vecs[2]  = '{"load rs2",      0, 9, 0, 0, 9, 2'b01, 0, 0, 0, 0, 0, 8'b1101_0000};
        vecs[3]  = '{"non-load",      5, 0, 0, 0, 5, 2'b00, 0, 0, 0, 0, 0, 8'b0000_0000};
        vecs[4]  = '{"branch+load",   5, 0, 0, 0, 5, 2'b01, 0, 0, 0, 0, 1, 8'b0011_0000};
        vecs[5]  = '{"branch",        0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 8'b0011_0000};
        vecs[6]  = '{"fwd mem prio",  0, 0, 7, 7, 0, 2'b00, 7, 1, 7, 1, 0, 8'b0000_1010};
        vecs[7]  = '{"fwd wb",        0, 0, 7, 7, 0, 2'b00, 7, 0, 7, 1, 0, 8'b0000_0101};
        vecs[8]  = '{"fwd x0",        0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 8'b0000_0000};
        vecs[9]  = '{"fwd split",     0, 0, 3, 4, 0, 2'b00, 3, 1, 4, 1, 0, 8'b0000_1001};
        vecs[10] = '{"fwd no wr",     0, 0, 3, 3, 0, 2'b00, 3, 0, 6, 1, 0, 8'b0000_0000};

        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("in reset outs", int'(actual_outs()), 8'b1011_0000);
        check_cnts("in reset");

        reset = 1'b0;
        #1;
        check("init cycle outs", int'(actual_outs()), 8'b1011_0000);
        tick();
        check("first run outs", int'(actual_outs()), 8'b0000_0000);
        check_cnts("after init");
        tick();
        check_cnts("idle run");

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #1;
            check(vecs[i].name, int'(actual_outs()), int'(vecs[i].exp));
            tick();
            check_cnts(vecs[i].name);
        end

        for (int n = 0; n < 400; n++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); ResultSrcE = 2'($urandom_range(0, 3));
            RdM  = 5'($urandom_range(0, 3)); RegWriteM = 1'($urandom_range(0, 1));
            RdW  = 5'($urandom_range(0, 3)); RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE  = 1'($urandom_range(0, 1));
            cnt_clr = ($urandom_range(0, 31) == 0);
            #1;
            check("random outs", int'(actual_outs()), int'(ref_outs()));
            tick();
            check_cnts("random");
        end

        // saturation: walk stall_cnt up to FFFE, then hold the stall past the limit
        set_idle();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        check_cnts("pre-sat clear");
        Rs1D = 5; RdE = 5; ResultSrcE = 2'b01;
        for (int n = 0; n < 65534; n++) tick();
        check("sat preload", int'(stall_cnt), 16'hFFFE);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("sat hold", int'(stall_cnt), 16'hFFFF);
        end
        check_cnts("saturated");
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        check("clr over stall", int'(stall_cnt), 0);
        check_cnts("after clr");

        // mid-stream reset with both counters nonzero and RUN-time outputs differing from INIT
        set_idle();
        PCSrcE = 1; tick();
        PCSrcE = 0; Rs1D = 5; RdE = 5; ResultSrcE = 2'b01; tick();
        check("pre-reset stall", int'(stall_cnt != 0), 1);
        check("pre-reset flush", int'(flush_cnt != 0), 1);
        set_idle();
        Rs1E = 7; RdM = 7; RegWriteM = 1;
        #1;
        check("pre-reset fwd", int'(ForwardAE), 2'b10);
        reset = 1'b1;
        m_run = 0; m_stall = 0; m_flush = 0;
        #1;
        check("async reset outs", int'(actual_outs()), 8'b1011_0000);
        check_cnts("async reset");
        tick();
        reset = 1'b0;
        #1;
        check("re-init outs", int'(actual_outs()), 8'b1011_0000);
        tick();
        check("re-run outs", int'(actual_outs()), int'(ref_outs()));
        check_cnts("re-run");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
